// File: rtl/iob_cache_line_reader_if.sv
// Bus bundle for the cache line reader: combinational data-memory read port
// plus the valid/ready word stream toward the back-end write channel.
interface iob_cache_line_reader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  be_valid;
    logic [ADDR_WIDTH-1:0] be_addr;
    logic [DATA_WIDTH-1:0] be_wdata;
    logic                  be_ready;

    modport master (
        output mem_addr,
        input  mem_rdata,
        output be_valid,
        output be_addr,
        output be_wdata,
        input  be_ready
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        input  be_valid,
        input  be_addr,
        input  be_wdata,
        output be_ready
    );
endinterface

// File: rtl/iob_cache_line_reader.sv
// Streams one cache line out of the data memory to the back-end, word by word.
// Optional abort input enabled by defining IOB_CACHE_LINE_READER_ABORT_EN.
module iob_cache_line_reader #(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
    parameter int ADDR_WIDTH = 10,
    parameter int LINE_OFF_W = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_WIDTH-LINE_OFF_W-1:0] line_addr,
`ifdef IOB_CACHE_LINE_READER_ABORT_EN
    input  logic                             abort,
`endif
    output logic                             busy,
    output logic                             done,
    iob_cache_line_reader_if.master          bus
);

    localparam logic [LINE_OFF_W-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t                           state, state_next;
    logic [ADDR_WIDTH-LINE_OFF_W-1:0] line_q;
    logic [LINE_OFF_W-1:0]            cnt;
    logic [LINE_OFF_W-1:0]            cnt_inc;
    logic                             busy_q;
    logic                             be_valid_q;
    logic [ADDR_WIDTH-1:0]            be_addr_q;
    logic [DATA_WIDTH-1:0]            be_wdata_q;
    logic [ADDR_WIDTH-1:0]            mem_addr_c;
    logic                             done_c;
    logic                             abort_hit;
    logic                             last_word;

    assign cnt_inc   = cnt + LINE_OFF_W'(1);
    assign last_word = (cnt == CNT_LAST);

`ifdef IOB_CACHE_LINE_READER_ABORT_EN
    logic abort_q;

    // Sticky until the FSM is back in IDLE; a single-cycle pulse is enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_q <= 1'b0;
        end else if (state_next == IDLE) begin
            abort_q <= 1'b0;
        end else if (abort && busy_q) begin
            abort_q <= 1'b1;
        end
    end

    assign abort_hit = abort_q;
`else
    assign abort_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = abort_hit ? IDLE : SEND;
            SEND: begin
                if (bus.be_ready) begin
                    if (abort_hit)      state_next = IDLE;
                    else if (last_word) state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic; SEND looks one word ahead so the next word is ready on accept
    always_comb begin
        mem_addr_c = {line_q, cnt};
        done_c     = 1'b0;
        case (state)
            SEND: mem_addr_c = {line_q, cnt_inc};
            DONE: done_c     = 1'b1;
            default: ;
        endcase
    end

    // Line index, word counter and the back-end output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q     <= '0;
            cnt        <= '0;
            be_valid_q <= 1'b0;
            be_addr_q  <= '0;
            be_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        line_q <= line_addr;
                        cnt    <= '0;
                    end
                end
                LOAD: begin
                    if (!abort_hit) begin
                        be_wdata_q <= bus.mem_rdata;
                        be_addr_q  <= mem_addr_c;
                        be_valid_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (bus.be_ready) begin
                        if (last_word || abort_hit) begin
                            be_valid_q <= 1'b0;
                        end else begin
                            be_wdata_q <= bus.mem_rdata;
                            be_addr_q  <= mem_addr_c;
                            cnt        <= cnt_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_c;
    assign bus.mem_addr = mem_addr_c;
    assign bus.be_valid = be_valid_q;
    assign bus.be_addr  = be_addr_q;
    assign bus.be_wdata = be_wdata_q;

endmodule

// File: tb/tb_iob_cache_line_reader.sv
// Directed bench for iob_cache_line_reader: memory word k holds 32'hA0+k.
// Define IOB_CACHE_LINE_READER_ABORT_EN to also exercise the abort path.
module tb_iob_cache_line_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] line_addr;
    logic       busy;
    logic       done;
    logic       abort;

    int n_checks;
    int n_errors;

    logic [31:0] mem [0:1023];

    iob_cache_line_reader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bif ();

    assign bif.mem_rdata = mem[bif.mem_addr];

    iob_cache_line_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .line_addr (line_addr),
`ifdef IOB_CACHE_LINE_READER_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .bus       (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts a line in the current cycle (cycle 0) and follows it to the idle cycle after done.
    task automatic run_line(input int line, input logic [15:0] rdy_pat, input bit poke,
                            output int done_cyc, output int first_cyc);
        int          cyc;
        int          got;
        bit          stall;
        bit          seen;
        logic [9:0]  h_a;
        logic [31:0] h_d;
        cyc = 0; got = 0; stall = 0; seen = 0;
        done_cyc = -1; first_cyc = -1; h_a = '0; h_d = '0;
        start = 1'b1;
        line_addr = 8'(line);
        tick;
        cyc = 1;
        start = 1'b0;
        chk("load_busy", 64'(busy), 64'd1);
        chk("load_valid", 64'(bif.be_valid), 64'd0);
        chk("load_maddr", 64'(bif.mem_addr), 64'(line * 4));
        tick;
        cyc = 2;
        while (cyc < 80) begin
            bif.be_ready = rdy_pat[(cyc - 2) % 16];
            start = poke && (cyc == 3);
            line_addr = (poke && cyc == 3) ? 8'(line + 7) : 8'(line);
            if (done) begin
                seen = 1;
                done_cyc = cyc;
                chk("done_valid", 64'(bif.be_valid), 64'd0);
                chk("done_busy", 64'(busy), 64'd1);
                break;
            end
            chk("valid_held", 64'(bif.be_valid), 64'd1);
            if (bif.be_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                chk("prefetch", 64'(bif.mem_addr), 64'(line * 4 + ((got + 1) % 4)));
                if (stall) begin
                    chk("hold_addr", 64'(bif.be_addr), 64'(h_a));
                    chk("hold_data", 64'(bif.be_wdata), 64'(h_d));
                end
                if (bif.be_ready) begin
                    chk("word_addr", 64'(bif.be_addr), 64'(line * 4 + got));
                    chk("word_data", 64'(bif.be_wdata), 64'(32'hA0 + line * 4 + got));
                    got++;
                    stall = 0;
                end else begin
                    stall = 1;
                    h_a = bif.be_addr;
                    h_d = bif.be_wdata;
                end
            end
            tick;
            cyc++;
        end
        start = 1'b0;
        chk("handshakes", 64'(got), 64'd4);
        chk("done_seen", 64'(seen), 64'd1);
        tick;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
    endtask

    initial begin
        int dc;
        int fc;
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < 1024; k++) mem[k] = 32'hA0 + k;
        rst_n = 1'b0;
        start = 1'b0;
        line_addr = '0;
        abort = 1'b0;
        bif.be_ready = 1'b0;
        tick;
        tick;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(bif.be_valid), 64'd0);
        chk("rst_addr", 64'(bif.be_addr), 64'd0);
        chk("rst_wdata", 64'(bif.be_wdata), 64'd0);
        chk("rst_maddr", 64'(bif.mem_addr), 64'd0);
        rst_n = 1'b1;
        tick;

        // Full-rate line 5
        run_line(5, 16'hFFFF, 1'b0, dc, fc);
        chk("t1_first_cyc", 64'(fc), 64'd2);
        chk("t1_done_cyc", 64'(dc), 64'd6);

        // be_ready 0,1,0,0,1,0,1,1,... : four stall cycles
        run_line(6, 16'hFED2, 1'b0, dc, fc);
        chk("t2_done_cyc", 64'(dc), 64'd10);

        // start during busy with another line is ignored
        run_line(9, 16'hFFFF, 1'b1, dc, fc);
        chk("t3_done_cyc", 64'(dc), 64'd6);

        // Back-to-back lines, second started at the first idle cycle
        run_line(1, 16'hFFFF, 1'b0, dc, fc);
        chk("t4a_done_cyc", 64'(dc), 64'd6);
        run_line(2, 16'hFFFF, 1'b0, dc, fc);
        chk("t4b_done_cyc", 64'(dc), 64'd6);

        // Reset while word 1 is presented
        start = 1'b1;
        line_addr = 8'd2;
        bif.be_ready = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        chk("t5_word1_addr", 64'(bif.be_addr), 64'd9);
        chk("t5_word1_valid", 64'(bif.be_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(bif.be_valid), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_done", 64'(done), 64'd0);
        chk("t5_rst_addr", 64'(bif.be_addr), 64'd0);
        chk("t5_rst_wdata", 64'(bif.be_wdata), 64'd0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        run_line(3, 16'hFFFF, 1'b0, dc, fc);
        chk("t5_first_cyc", 64'(fc), 64'd2);

`ifdef IOB_CACHE_LINE_READER_ABORT_EN
        // Abort pulsed during word 1 while the back-end stalls
        start = 1'b1;
        line_addr = 8'd1;
        bif.be_ready = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("ab_word0_addr", 64'(bif.be_addr), 64'd4);
        tick;
        bif.be_ready = 1'b0;
        abort = 1'b1;
        chk("ab_word1_addr", 64'(bif.be_addr), 64'd5);
        tick;
        abort = 1'b0;
        chk("ab_hold_valid", 64'(bif.be_valid), 64'd1);
        chk("ab_hold_addr", 64'(bif.be_addr), 64'd5);
        tick;
        bif.be_ready = 1'b1;
        chk("ab_final_addr", 64'(bif.be_addr), 64'd5);
        chk("ab_final_data", 64'(bif.be_wdata), 64'hA5);
        tick;
        chk("ab_end_valid", 64'(bif.be_valid), 64'd0);
        chk("ab_end_busy", 64'(busy), 64'd0);
        chk("ab_end_done", 64'(done), 64'd0);
        tick;
        chk("ab_no_done", 64'(done), 64'd0);
        chk("ab_idle_busy", 64'(busy), 64'd0);
        run_line(4, 16'hFFFF, 1'b0, dc, fc);
        chk("ab_after_done_cyc", 64'(dc), 64'd6);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/iob_cache_line_reader.md
# iob_cache_line_reader

Write-back line reader for the cache data memory. On a start request it reads every word of one cache line out of the byte-enabled data register file, using its combinational read port, and streams the words in ascending order to the back-end over a valid/ready interface. It sits between the cache data memory and the back-end write channel, and it is the read-side counterpart of the logic that fills the data memory.

## Interface
- NUM_COL, 4, byte columns per word
- COL_WIDTH, 8, bits per column
- DATA_WIDTH, NUM_COL*COL_WIDTH, word width
- ADDR_WIDTH, 10, data memory word address width
- LINE_OFF_W, 2, log2 of words per line (W = 2**LINE_OFF_W); must be at least 1 and less than ADDR_WIDTH

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request write-back of one line; sampled only in IDLE
- line_addr  in  ADDR_WIDTH-LINE_OFF_W  line index; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last word is accepted
- mem_addr  out  ADDR_WIDTH  data memory read address
- mem_rdata  in  DATA_WIDTH  data memory read data, combinational from mem_addr
- be_valid  out  1  back-end word valid
- be_addr  out  ADDR_WIDTH  word address {line, offset}
- be_wdata  out  DATA_WIDTH  word data
- be_ready  in  1  back-end accepts the word

## Operation
- The FSM has four states: IDLE, LOAD, SEND and DONE. It holds a registered line index `line_q` and a word counter `cnt` of LINE_OFF_W bits.
- **IDLE**
  - start=1 latches line_addr into `line_q` and clears `cnt` to 0.
  - The next state is LOAD.
- **LOAD**
  - mem_addr = {line_q, cnt}.
  - At the clock edge, mem_rdata is captured into be_wdata, {line_q, cnt} is captured into be_addr, and be_valid is set.
  - The next state is SEND.
- **SEND**
  - mem_addr = {line_q, cnt+1}, which prefetches the next word.
  - If be_ready=1 and cnt≠W-1: be_wdata captures mem_rdata, be_addr captures {line_q, cnt+1}, `cnt` increments, and be_valid stays 1. This gives back-to-back words.
  - If be_ready=1 and cnt=W-1: be_valid clears and the next state is DONE.
  - If be_ready=0: the FSM stays in SEND. be_valid, be_addr and be_wdata are held stable.
- **DONE**
  - done=1 for exactly this one cycle.
  - The next state is IDLE.
- Handshake rules:
  - Once be_valid rises, it does not fall until the handshake completes.
  - be_addr and be_wdata do not change while be_valid=1 and be_ready=0.
- start is ignored in every state other than IDLE. A start that arrives during DONE is lost.
- Outside LOAD and SEND, mem_addr = {line_q, cnt}. It has no side effects, because the read port is combinational.
- The counter arithmetic is modulo 2**LINE_OFF_W. `cnt` never wraps inside a line, because the transition out of SEND at cnt=W-1 happens before any wrap.
- The caller holds the data memory contents of the line stable while busy=1.

## Timing
- Reset values: state IDLE, busy 0, done 0, be_valid 0, be_addr 0, be_wdata 0, mem_addr 0, line_q 0, cnt 0.
- With start in cycle 0:
  - LOAD is in cycle 1.
  - The first be_valid is in cycle 2.
  - With be_ready held at 1, words 0..W-1 are presented in cycles 2..W+1.
  - done is in cycle W+2.
  - The earliest next start is accepted in cycle W+3.
- Each cycle with be_ready=0 in SEND adds one cycle of latency.
- busy is registered and is exactly (state≠IDLE).
- When rst_n is asserted mid-line, all outputs go to their reset values immediately. No done pulse is produced, and the partial line is not resumed.

## Configuration
- Macro: IOB_CACHE_LINE_READER_ABORT_EN.
- **Defined:**
  - An extra input port `abort` (1 bit) is present. It sets a sticky abort flag when it is sampled high while busy=1; a pulse is sufficient.
  - With the flag set, LOAD goes straight to IDLE without raising be_valid.
  - With the flag set, SEND finishes the in-flight word's handshake and then goes to IDLE.
  - An aborted line never produces a done pulse. The flag clears on entry to IDLE.
- **Undefined:** the `abort` port does not exist, and every started line runs to DONE.

## Test plan
- Reset, then memory word k = 32'hA0+k, start with line_addr=5 and be_ready=1 → be_addr 20,21,22,23 and be_wdata A0+20..A0+23 in consecutive cycles 2..5, done in cycle 6.
- be_ready toggled 0,1,0,0,1,... → each word is held stable while be_ready=0, there are no duplicated or skipped words, and exactly 4 handshakes occur.
- start pulsed while busy=1 with a different line_addr → ignored, and the first line completes unchanged.
- Two starts back to back, each issued at the first cycle busy=0 → two full lines, each followed by its own done pulse.
- rst_n asserted while be_valid=1 after word 1 → be_valid, busy and done are 0 immediately, and a fresh start afterwards streams from offset 0.
- With ABORT_EN, abort is pulsed during SEND of word 1 while be_ready=0 → word 1 completes when be_ready rises, no further words are sent, and the block returns to IDLE with no done pulse.
